// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: IF/OF and OF/EX registers, integer register file,
// field/immediate decode and the forwarding operand mux feeding execute.
module operand_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        stall_ifof,
  input  logic        stall_ofex,
  input  logic        fwd_rs1_enable,
  input  logic [31:0] fwd_rs1_data,
  input  logic        fwd_rs2_enable,
  input  logic [31:0] fwd_rs2_data,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        of_valid_opcode,
  output logic [4:0]  of_rs1_sel,
  output logic [4:0]  of_rs2_sel,
  output logic        ex_valid,
  output logic        ex_valid_opcode,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // IF/OF register
  logic        ifof_valid_q, ifof_valid_d;
  logic [31:0] ifof_instr_q, ifof_instr_d;
  logic [31:0] ifof_pc_q,    ifof_pc_d;

  always_comb begin
    ifof_valid_d = ifof_valid_q;
    ifof_instr_d = ifof_instr_q;
    ifof_pc_d    = ifof_pc_q;
    if (flush) begin
      ifof_valid_d = 1'b0;
      ifof_instr_d = NOP_INSTR;
      ifof_pc_d    = 32'd0;
    end else if (!stall_ifof) begin
      ifof_valid_d = if_valid;
      ifof_instr_d = if_instr;
      ifof_pc_d    = if_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifof_valid_q <= 1'b0;
      ifof_instr_q <= NOP_INSTR;
      ifof_pc_q    <= 32'd0;
    end else begin
      ifof_valid_q <= ifof_valid_d;
      ifof_instr_q <= ifof_instr_d;
      ifof_pc_q    <= ifof_pc_d;
    end
  end

  // Decode of the OF slot
  logic [31:0] ins;
  logic        dec_recog, dec_use1, dec_use2, dec_wrd;
  logic [31:0] dec_imm;
  logic [4:0]  of_rd;

  assign ins = ifof_instr_q;

  always_comb begin
    dec_recog = 1'b1;
    dec_use1  = 1'b0;
    dec_use2  = 1'b0;
    dec_wrd   = 1'b0;
    dec_imm   = 32'd0;
    case (ins[6:0])
      OP_LUI, OP_AUIPC: begin
        dec_wrd = 1'b1;
        dec_imm = {ins[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_wrd = 1'b1;
        dec_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        dec_use1 = 1'b1;
        dec_wrd  = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[31:20]};
      end
      OP_BRANCH: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_STORE: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_OP: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_wrd  = 1'b1;
      end
      OP_MISC, OP_SYSTEM: ;
      default: dec_recog = 1'b0;
    endcase
  end

  // Invalid slots present no sources so dependency control never stalls on them
  assign of_valid_opcode = ifof_valid_q && dec_recog;
  assign of_rs1_sel      = (ifof_valid_q && dec_use1) ? ins[19:15] : 5'd0;
  assign of_rs2_sel      = (ifof_valid_q && dec_use2) ? ins[24:20] : 5'd0;
  assign of_rd           = (ifof_valid_q && dec_wrd)  ? ins[11:7]  : 5'd0;

  // Register file
  logic [31:0][31:0] rf_q, rf_d;
  logic [31:0]       rd1_data, rd2_data;

  always_comb begin
    rf_d = rf_q;
    if (wb_enable && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rf_q <= '0;
    else         rf_q <= rf_d;
  end

  always_comb begin
    rd1_data = rf_q[of_rs1_sel];
    rd2_data = rf_q[of_rs2_sel];
    if (WB_BYPASS && wb_enable && wb_addr == of_rs1_sel) rd1_data = wb_data;
    if (WB_BYPASS && wb_enable && wb_addr == of_rs2_sel) rd2_data = wb_data;
    if (of_rs1_sel == 5'd0) rd1_data = 32'd0;
    if (of_rs2_sel == 5'd0) rd2_data = 32'd0;
  end

  // OF/EX register
  logic        ex_valid_q, ex_valid_d;
  logic        ex_vop_q,   ex_vop_d;
  logic [31:0] ex_pc_q,    ex_pc_d;
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [4:0]  ex_rs1_q,   ex_rs1_d;
  logic [4:0]  ex_rs2_q,   ex_rs2_d;
  logic [31:0] ex_imm_q,   ex_imm_d;
  logic [31:0] ex_d1_q,    ex_d1_d;
  logic [31:0] ex_d2_q,    ex_d2_d;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_vop_d   = ex_vop_q;
    ex_pc_d    = ex_pc_q;
    ex_instr_d = ex_instr_q;
    ex_rd_d    = ex_rd_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_d1_d    = ex_d1_q;
    ex_d2_d    = ex_d2_q;
    if (!flush && stall_ofex) begin
      // Held instruction keeps its operands current with retiring writes
      if (ex_valid_q && wb_enable && wb_addr != 5'd0) begin
        if (wb_addr == ex_rs1_q) ex_d1_d = wb_data;
        if (wb_addr == ex_rs2_q) ex_d2_d = wb_data;
      end
    end else if (flush || stall_ifof || !ifof_valid_q) begin
      ex_valid_d = 1'b0;
      ex_vop_d   = 1'b0;
      ex_pc_d    = 32'd0;
      ex_instr_d = NOP_INSTR;
      ex_rd_d    = 5'd0;
      ex_rs1_d   = 5'd0;
      ex_rs2_d   = 5'd0;
      ex_imm_d   = 32'd0;
      ex_d1_d    = 32'd0;
      ex_d2_d    = 32'd0;
    end else begin
      ex_valid_d = 1'b1;
      ex_vop_d   = dec_recog;
      ex_pc_d    = ifof_pc_q;
      ex_instr_d = ifof_instr_q;
      ex_rd_d    = of_rd;
      ex_rs1_d   = of_rs1_sel;
      ex_rs2_d   = of_rs2_sel;
      ex_imm_d   = dec_imm;
      ex_d1_d    = rd1_data;
      ex_d2_d    = rd2_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= 1'b0;
      ex_vop_q   <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_instr_q <= NOP_INSTR;
      ex_rd_q    <= 5'd0;
      ex_rs1_q   <= 5'd0;
      ex_rs2_q   <= 5'd0;
      ex_imm_q   <= 32'd0;
      ex_d1_q    <= 32'd0;
      ex_d2_q    <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_vop_q   <= ex_vop_d;
      ex_pc_q    <= ex_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_d1_q    <= ex_d1_d;
      ex_d2_q    <= ex_d2_d;
    end
  end

  assign ex_valid        = ex_valid_q;
  assign ex_valid_opcode = ex_vop_q;
  assign ex_pc           = ex_pc_q;
  assign ex_instr        = ex_instr_q;
  assign ex_rd           = ex_rd_q;
  assign ex_rs1          = ex_rs1_q;
  assign ex_rs2          = ex_rs2_q;
  assign ex_imm          = ex_imm_q;

  // x0 sources stay zero even if dependency control raises a forward
  assign ex_rs1_data = (ex_rs1_q == 5'd0) ? 32'd0 : (fwd_rs1_enable ? fwd_rs1_data : ex_d1_q);
  assign ex_rs2_data = (ex_rs2_q == 5'd0) ? 32'd0 : (fwd_rs2_enable ? fwd_rs2_data : ex_d2_q);

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: decode/operand vector table plus
// stall, flush, bypass and reset sequences.
module tb_operand_fetch_stage;

  logic        clk, resetn;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        flush, stall_ifof, stall_ofex;
  logic        fwd_rs1_enable, fwd_rs2_enable;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        of_valid_opcode;
  logic [4:0]  of_rs1_sel, of_rs2_sel;
  logic        ex_valid, ex_valid_opcode;
  logic [31:0] ex_pc, ex_instr;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_imm, ex_rs1_data, ex_rs2_data;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage dut (
    .clk(clk), .resetn(resetn),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .stall_ifof(stall_ifof), .stall_ofex(stall_ofex),
    .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_enable(fwd_rs2_enable), .fwd_rs2_data(fwd_rs2_data),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .of_valid_opcode(of_valid_opcode), .of_rs1_sel(of_rs1_sel), .of_rs2_sel(of_rs2_sel),
    .ex_valid(ex_valid), .ex_valid_opcode(ex_valid_opcode),
    .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        f1e;
    logic [31:0] f1;
    logic        f2e;
    logic [31:0] f2;
    logic        vop;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, d1, d2;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_enable = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_enable = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    flush = 1'b0; stall_ifof = 1'b0; stall_ofex = 1'b0;
    fwd_rs1_enable = 1'b0; fwd_rs1_data = 32'h0;
    fwd_rs2_enable = 1'b0; fwd_rs2_data = 32'h0;
    wb_enable = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;

    //           instr         f1e  f1            f2e  f2            vop rd  rs1 rs2 imm           d1            d2
    vt[0] = '{32'h00500093, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd1, 5'd0, 5'd0, 32'h00000005, 32'h0,        32'h0};
    vt[1] = '{32'h00500093, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 5'd1, 5'd0, 5'd0, 32'h00000005, 32'h0,        32'h0};
    vt[2] = '{32'h002101B3, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd3, 5'd2, 5'd2, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[3] = '{32'h0020A423, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b1, 5'd0, 5'd1, 5'd2, 32'h00000008, 32'h00000100, 32'h12345678};
    vt[4] = '{32'hFE000EE3, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h0,        32'h0};
    vt[5] = '{32'hFF9FF0EF, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8, 32'h0,        32'h0};
    vt[6] = '{32'hABCDE2B7, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd5, 5'd0, 5'd0, 32'hABCDE000, 32'h0,        32'h0};
    vt[7] = '{32'h0000007F, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h00000000, 32'h0,        32'h0};
    vt[8] = '{32'hFFC0A203, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd4, 5'd1, 5'd0, 32'hFFFFFFFC, 32'h00000100, 32'h0};
    vt[9] = '{32'h002101B3, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1, 5'd3, 5'd2, 5'd2, 32'h00000000, 32'h11111111, 32'hDEADBEEF};

    #12;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_instr", ex_instr, 32'h00000013);
    chk("rst_of_vop", {31'd0, of_valid_opcode}, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_rs1_data", ex_rs1_data, 32'd0);
    resetn = 1'b1;
    tick();

    wb_write(5'd1, 32'h00000100);
    wb_write(5'd2, 32'hDEADBEEF);
    wb_write(5'd0, 32'hFFFFFFFF);

    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1; if_instr = vt[i].instr; if_pc = 32'h1000 + 32'(i * 4);
      tick();
      if_valid = 1'b0;
      chk($sformatf("v%0d_of_vop", i), {31'd0, of_valid_opcode}, {31'd0, vt[i].vop});
      chk($sformatf("v%0d_of_rs1", i), {27'd0, of_rs1_sel}, {27'd0, vt[i].rs1});
      tick();
      fwd_rs1_enable = vt[i].f1e; fwd_rs1_data = vt[i].f1;
      fwd_rs2_enable = vt[i].f2e; fwd_rs2_data = vt[i].f2;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_vop", i), {31'd0, ex_valid_opcode}, {31'd0, vt[i].vop});
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_instr", i), ex_instr, vt[i].instr);
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vt[i].rd});
      chk($sformatf("v%0d_rs1", i), {27'd0, ex_rs1}, {27'd0, vt[i].rs1});
      chk($sformatf("v%0d_rs2", i), {27'd0, ex_rs2}, {27'd0, vt[i].rs2});
      chk($sformatf("v%0d_imm", i), ex_imm, vt[i].imm);
      chk($sformatf("v%0d_d1", i), ex_rs1_data, vt[i].d1);
      chk($sformatf("v%0d_d2", i), ex_rs2_data, vt[i].d2);
      fwd_rs1_enable = 1'b0; fwd_rs2_enable = 1'b0;
    end

    // One-cycle IF/OF stall: bubble then unchanged issue
    if_valid = 1'b1; if_instr = 32'h002101B3; if_pc = 32'h200;
    tick();
    if_valid = 1'b0; stall_ifof = 1'b1;
    tick();
    chk("stl_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("stl_bubble_instr", ex_instr, 32'h00000013);
    chk("stl_of_rs1", {27'd0, of_rs1_sel}, 32'd2);
    stall_ifof = 1'b0;
    tick();
    chk("stl_issue_valid", {31'd0, ex_valid}, 32'd1);
    chk("stl_issue_instr", ex_instr, 32'h002101B3);
    chk("stl_issue_pc", ex_pc, 32'h200);

    // Writeback in the capture cycle is bypassed into the captured operands
    if_valid = 1'b1; if_instr = 32'h002101B3; if_pc = 32'h300;
    tick();
    if_valid = 1'b0; wb_enable = 1'b1; wb_addr = 5'd2; wb_data = 32'h0BADF00D;
    tick();
    wb_enable = 1'b0;
    chk("byp_d1", ex_rs1_data, 32'h0BADF00D);
    chk("byp_d2", ex_rs2_data, 32'h0BADF00D);

    // Held OF/EX operand refreshed by writeback: ADDI x6,x5,1
    if_valid = 1'b1; if_instr = 32'h00128313; if_pc = 32'h400;
    tick();
    if_valid = 1'b0;
    tick();
    chk("hold_pre_d1", ex_rs1_data, 32'd0);
    stall_ofex = 1'b1; stall_ifof = 1'b1;
    wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 32'h00000055;
    tick();
    wb_enable = 1'b0;
    tick();
    tick();
    chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    chk("hold_instr", ex_instr, 32'h00128313);
    chk("hold_pc", ex_pc, 32'h400);
    chk("hold_rs1", {27'd0, ex_rs1}, 32'd5);
    chk("hold_d1", ex_rs1_data, 32'h00000055);
    stall_ofex = 1'b0; stall_ifof = 1'b0;

    // Flush wins over stall in both registers
    if_valid = 1'b1; if_instr = 32'h002101B3; if_pc = 32'h500;
    tick();
    if_instr = 32'h0020A423; if_pc = 32'h504;
    tick();
    if_valid = 1'b0;
    chk("fl_pre_of_vop", {31'd0, of_valid_opcode}, 32'd1);
    chk("fl_pre_ex_valid", {31'd0, ex_valid}, 32'd1);
    flush = 1'b1; stall_ofex = 1'b1; stall_ifof = 1'b1;
    tick();
    flush = 1'b0; stall_ofex = 1'b0; stall_ifof = 1'b0;
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_ex_instr", ex_instr, 32'h00000013);
    chk("fl_of_vop", {31'd0, of_valid_opcode}, 32'd0);
    chk("fl_of_rs1", {27'd0, of_rs1_sel}, 32'd0);

    // Reset during a stall restarts empty
    if_valid = 1'b1; if_instr = 32'h002101B3; if_pc = 32'h600;
    tick();
    tick();
    if_valid = 1'b0; stall_ofex = 1'b1; stall_ifof = 1'b1;
    tick();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    stall_ofex = 1'b0; stall_ifof = 1'b0;
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("rs_ex_valid2", {31'd0, ex_valid}, 32'd0);
    chk("rs_ex_instr", ex_instr, 32'h00000013);
    chk("rs_of_vop", {31'd0, of_valid_opcode}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
